decoded_reg_bank: RTL and testbench
===================================

Name: decoded_reg_bank

Overview:
- 32-entry x 32-bit register bank, the write-side counterpart of the bit-level 32:1 read selection.
- A 5-to-32 one-hot write decoder steers write data into exactly one register on a clock edge.
- Two independent combinational read ports select registers back out.
- Sits in the MIPS datapath as the GPR file; register 0 is hardwired zero.

Parameters:
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, select width; register count = 2**ADDR_WIDTH = 32

Ports:
- clock  input  1  single system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- write_enable  input  1  commit write_data this edge
- write_select  input  ADDR_WIDTH  destination register index
- write_data  input  DATA_WIDTH  data to store
- write_lines  output  32  registered one-hot copy of the last decoded write strobe (debug/hazard use)
- read_select_a  input  ADDR_WIDTH  port A register index
- read_select_b  input  ADDR_WIDTH  port B register index
- read_data_a  output  DATA_WIDTH  contents of register read_select_a
- read_data_b  output  DATA_WIDTH  contents of register read_select_b

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-high, on port `reset`.
- Reset:
  - On a rising edge with reset=1, all 32 registers become 0 and write_lines becomes 0.
  - Reset has priority over a simultaneous write; that write is dropped.
  - Reset mid-sequence discards all prior contents.
- Write decode:
  - strobe[i] = write_enable & (write_select == i), for i = 1..31.
  - strobe[0] is forced to 0.
  - At most one strobe is set per cycle.
- Write commit:
  - On a rising edge with reset=0 and strobe[i]=1, reg[i] <= write_data.
  - Latency is 1 cycle: the value is visible on the read ports in the cycle after the edge.
  - Registers with strobe=0 hold their value.
- write_lines:
  - Registered strobe vector: write_lines <= strobe each edge.
  - Goes to 0 in any cycle with no write, or with a write to register 0.
- Register 0:
  - Never stored.
  - read_data_x = 0 whenever read_select_x = 0, regardless of any write.
- Read:
  - Purely combinational from the current register contents.
  - Both ports are independent and may select the same register.
- Same-cycle read/write of one register (without the optional feature):
  - The read returns the old value.
  - The new value appears the following cycle.
- Width rules:
  - No arithmetic; write_data is stored unmodified at full DATA_WIDTH.
  - Select values are always in range (5 bits, 32 entries), so there is no out-of-range case.

Optional Feature:
- Macro: DECODED_REG_BANK_WRITE_BYPASS_EN.
- When defined, each read port forwards write_data combinationally when all of these hold in the same cycle:
  - write_enable = 1
  - write_select = read_select_x
  - write_select != 0
  - reset = 0
- This gives MIPS write-before-read semantics.
- When undefined, no forwarding: the read returns the stored (old) value in that cycle.
- Stored contents and write_lines are identical in both builds.

Decomposition:
- Shared package `reg_bank_pkg`:
  - DATA_WIDTH / ADDR_WIDTH constants
  - REG_COUNT = 32
  - ZERO_REG index constant = 0
  - typedefs reg_index_t (logic [4:0]) and reg_word_t (logic [31:0])
- Sub-module `decoder_5_32`:
  - Combinational 5-to-32 one-hot decoder with enable input.
  - Is the inverse of the bit-select mux and is reusable elsewhere in the datapath.
  - Instantiated once for the write strobes.
- The register bank instantiates decoder_5_32 and implements the read-select logic.

Test Plan:
- Reset clears: write 0xDEADBEEF to regs 1..31, then assert reset one cycle → every read_data = 0x00000000 and write_lines = 0.
- Basic write/read: write 0x12345678 to reg 5 → next cycle read_select_a=5 gives 0x12345678 and write_lines = 0x00000020; reg 4 and reg 6 still read 0.
- Register 0 immutable: write 0xFFFFFFFF to reg 0 → read_select_a=0 gives 0x00000000 and write_lines = 0.
- Same-cycle read/write: reg 7 holds 0xAAAA0000; write 0x5555FFFF to reg 7 while read_select_b=7:
  - macro off: 0xAAAA0000 in that cycle, 0x5555FFFF in the next;
  - macro on: 0x5555FFFF immediately.
- Reset-vs-write priority: reset=1 with write_enable=1, write_select=31, data 0xCAFEBABE → reg 31 reads 0 afterward.
- Dual port plus hold: fill reg i with i*0x01010101, then sweep read_select_a ascending and read_select_b descending for 32 cycles with write_enable=0 → every read matches, no register changes.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared constants and types for the decoded GPR bank.
//   DATA_WIDTH / ADDR_WIDTH : register width and select width
//   REG_COUNT               : number of registers (2**ADDR_WIDTH)
//   ZERO_REG                : index of the hardwired-zero register
//   reg_index_t / reg_word_t: select and data word types
//   onehot_of()             : reference one-hot encoding of an index
package reg_bank_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned REG_COUNT  = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_index_t;
  typedef logic [DATA_WIDTH-1:0] reg_word_t;

  localparam reg_index_t ZERO_REG = '0;

  function automatic logic [REG_COUNT-1:0] onehot_of(input reg_index_t idx);
    logic [REG_COUNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_5_32.sv
// decoder_5_32: combinational 5-to-32 one-hot decoder with enable.
//   enable_i : when 0, all outputs are 0
//   sel_i    : index to decode
//   onehot_o : bit sel_i set when enabled, all others 0
module decoder_5_32
  import reg_bank_pkg::*;
(
  input  logic                 enable_i,
  input  reg_index_t           sel_i,
  output logic [REG_COUNT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      onehot_o[i] = enable_i && (sel_i == reg_index_t'(i));
    end
  end

endmodule

// File: rtl/decoded_reg_bank.sv
// decoded_reg_bank: 32 x 32-bit GPR bank, register 0 hardwired to zero.
//   clock          : rising-edge system clock
//   reset          : synchronous active-high; clears all registers and write_lines
//   write_enable   : commit write_data to write_select this edge
//   write_select   : destination register index
//   write_data     : data to store
//   write_lines    : registered one-hot write strobe of the previous edge
//   read_select_a/b: combinational read port indices
//   read_data_a/b  : contents of the selected registers
// Build option: define DECODED_REG_BANK_WRITE_BYPASS_EN to forward a same-cycle
// write to a matching read port (write-before-read). Storage is identical
// with or without it.
module decoded_reg_bank #(
  parameter int unsigned DATA_WIDTH = reg_bank_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = reg_bank_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_select,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [31:0]           write_lines,
  input  logic [ADDR_WIDTH-1:0] read_select_a,
  input  logic [ADDR_WIDTH-1:0] read_select_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b
);

  import reg_bank_pkg::REG_COUNT;
  import reg_bank_pkg::ZERO_REG;

  logic [REG_COUNT-1:0]  dec_lines;
  logic [REG_COUNT-1:0]  strobe;
  logic [REG_COUNT-1:0]  write_lines_d;
  logic [REG_COUNT-1:0]  write_lines_q;
  // Register 0 has no storage; entries start at index 1.
  logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];

  decoder_5_32 u_write_dec (
    .enable_i (write_enable),
    .sel_i    (write_select),
    .onehot_o (dec_lines)
  );

  // A write to register 0 never strobes anything.
  always_comb begin
    strobe           = dec_lines;
    strobe[ZERO_REG] = 1'b0;
    write_lines_d    = strobe;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_lines_q <= '0;
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      write_lines_q <= write_lines_d;
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
        if (strobe[i]) begin
          regs_q[i] <= write_data;
        end
      end
    end
  end

  assign write_lines = write_lines_q;

  // Read mux scans 1..31 only, so select 0 falls through to the zero default.
  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      if (read_select_a == ADDR_WIDTH'(i)) read_data_a = regs_q[i];
      if (read_select_b == ADDR_WIDTH'(i)) read_data_b = regs_q[i];
    end
`ifdef DECODED_REG_BANK_WRITE_BYPASS_EN
    if (write_enable && !reset && (write_select != ADDR_WIDTH'(ZERO_REG))) begin
      if (write_select == read_select_a) read_data_a = write_data;
      if (write_select == read_select_b) read_data_b = write_data;
    end
`else
`endif
  end

endmodule

// File: tb/tb_decoded_reg_bank.sv
module tb_decoded_reg_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [4:0]  write_select;
  logic [31:0] write_data;
  logic [31:0] write_lines;
  logic [4:0]  read_select_a;
  logic [4:0]  read_select_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;

  int errors = 0;
  int checks = 0;

  decoded_reg_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (write_enable),
    .write_select  (write_select),
    .write_data    (write_data),
    .write_lines   (write_lines),
    .read_select_a (read_select_a),
    .read_select_b (read_select_b),
    .read_data_a   (read_data_a),
    .read_data_b   (read_data_b)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] sel, input logic [31:0] data);
    write_enable = 1'b1;
    write_select = sel;
    write_data   = data;
    tick();
    write_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    reset = 1'b1; write_enable = 1'b0; write_select = '0; write_data = '0;
    read_select_a = '0; read_select_b = '0;
    tick(); tick();
    reset = 1'b0;
    read_select_a = 5'd1; read_select_b = 5'd31;
    #1;
    check("reset_wl", write_lines, 32'h0);
    check("reset_r1", read_data_a, 32'h0);
    check("reset_r31", read_data_b, 32'h0);

    // Fill 1..31 then reset clears everything
    for (int i = 1; i < 32; i++) begin
      write_select = 5'(i); write_data = 32'hDEADBEEF; write_enable = 1'b1;
      tick();
    end
    check("fill_wl31", write_lines, 32'h8000_0000);
    write_enable = 1'b0;
    #1;
    check("fill_r1", read_data_a, 32'hDEADBEEF);
    check("fill_r31", read_data_b, 32'hDEADBEEF);
    tick();
    check("idle_wl", write_lines, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_wl", write_lines, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read_select_a = 5'(i); read_select_b = 5'(31 - i);
      #1;
      check("rst2_ra", read_data_a, 32'h0);
      check("rst2_rb", read_data_b, 32'h0);
    end

    // Basic write/read
    write_reg(5'd5, 32'h12345678);
    check("basic_wl", write_lines, 32'h0000_0020);
    read_select_a = 5'd5; read_select_b = 5'd4;
    #1;
    check("basic_r5", read_data_a, 32'h12345678);
    check("basic_r4", read_data_b, 32'h0);
    read_select_b = 5'd6;
    #1;
    check("basic_r6", read_data_b, 32'h0);

    // Register 0 immutable, bypass never applies to it
    read_select_a = 5'd0;
    write_enable = 1'b1; write_select = 5'd0; write_data = 32'hFFFFFFFF;
    #1;
    check("r0_same_cycle", read_data_a, 32'h0);
    tick();
    write_enable = 1'b0;
    #1;
    check("r0_wl", write_lines, 32'h0);
    check("r0_read", read_data_a, 32'h0);

    // Same-cycle read/write of register 7
    write_reg(5'd7, 32'hAAAA0000);
    read_select_b = 5'd7;
    write_enable = 1'b1; write_select = 5'd7; write_data = 32'h5555FFFF;
    #1;
`ifdef DECODED_REG_BANK_WRITE_BYPASS_EN
    check("rw_same", read_data_b, 32'h5555FFFF);
`else
    check("rw_same", read_data_b, 32'hAAAA0000);
`endif
    tick();
    write_enable = 1'b0;
    #1;
    check("rw_next", read_data_b, 32'h5555FFFF);
    check("rw_wl", write_lines, 32'h0000_0080);

    // Reset beats a simultaneous write (and suppresses forwarding)
    write_reg(5'd31, 32'h01234567);
    read_select_a = 5'd31;
    reset = 1'b1; write_enable = 1'b1; write_select = 5'd31; write_data = 32'hCAFEBABE;
    #1;
    check("prio_during", read_data_a, 32'h01234567);
    tick();
    reset = 1'b0; write_enable = 1'b0;
    #1;
    check("prio_r31", read_data_a, 32'h0);
    check("prio_wl", write_lines, 32'h0);
    read_select_b = 5'd7;
    #1;
    check("prio_r7", read_data_b, 32'h0);

    // Dual-port sweep with hold
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    for (int c = 0; c < 32; c++) begin
      read_select_a = 5'(c); read_select_b = 5'(31 - c);
      #1;
      e = 32'(c) * 32'h01010101;
      check("sweep_a", read_data_a, e);
      e = 32'(31 - c) * 32'h01010101;
      check("sweep_b", read_data_b, e);
      tick();
    end
    check("sweep_wl", write_lines, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
